// File: rtl/param_fifo.sv
// param_fifo: parameterised synchronous FIFO with occupancy flags and sticky overflow/underflow.
// Define FIFO_FWFT_EN for first-word-fall-through data_out; by default data_out is registered.
module param_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 4,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             write_enb,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic             w_wr_accept;
  logic             w_rd_accept;
  logic [PW-1:0]    w_wr_ptr_nxt;
  logic [PW-1:0]    w_rd_ptr_nxt;

  // Flags decode straight from the registered occupancy, so they track count with no lag.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // Handshake: write_enb and read are requests; !full and !empty are their readies.
  // A request is taken on the rising edge where its ready is high and clear is low.
  assign w_wr_accept = write_enb && !w_full && !clear;
  assign w_rd_accept = read && !w_empty && !clear;

  // Explicit wrap keeps non-power-of-two depths inside the storage array.
  assign w_wr_ptr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PW'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_accept) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_rd_accept) r_rd_ptr <= w_rd_ptr_nxt;
      case ({w_wr_accept, w_rd_accept})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (write_enb && w_full) r_overflow  <= 1'b1;
      if (read && w_empty)     r_underflow <= 1'b1;
    end
  end

  // Storage is never reset; a stray write during reset lands at slot 0, which the
  // next accepted write overwrites before any read can reach it.
  always_ff @(posedge clk) begin
    if (w_wr_accept) r_mem[r_wr_ptr] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  assign data_out = w_empty ? '0 : r_mem[r_rd_ptr];
`else
  logic [WIDTH-1:0] r_data_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_out <= '0;
    end else if (clear) begin
      r_data_out <= '0;
    end else if (w_rd_accept) begin
      r_data_out <= r_mem[r_rd_ptr];
    end
  end

  assign data_out = r_data_out;
`endif

  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_empty = (r_count <= CW'(AEMPTY_TH));
  assign almost_full  = (r_count >= CW'(AFULL_TH));
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_param_fifo.sv
// Testbench for param_fifo: a DEPTH=16 and a DEPTH=10 instance checked against queue models.
module tb_param_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       wr0 = 1'b0, rd0 = 1'b0, wr1 = 1'b0, rd1 = 1'b0;
  logic [7:0] din0 = 8'h00, din1 = 8'h00;
  logic [7:0] dout0, dout1;
  logic       emp0, ful0, ae0, af0, ovf0, unf0;
  logic       emp1, ful1, ae1, af1, ovf1, unf1;
  logic [4:0] cnt0;
  logic [3:0] cnt1;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic       exp_ovf0 = 1'b0, exp_unf0 = 1'b0, exp_ovf1 = 1'b0, exp_unf1 = 1'b0;
  logic [7:0] exp_reg0 = 8'h00, exp_reg1 = 8'h00;
  int         checks = 0;
  int         errors = 0;

  param_fifo #(.WIDTH(8), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(4)) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .write_enb(wr0), .data_in(din0),
    .read(rd0), .data_out(dout0), .empty(emp0), .full(ful0), .almost_empty(ae0),
    .almost_full(af0), .count(cnt0), .overflow(ovf0), .underflow(unf0)
  );

  param_fifo #(.WIDTH(8), .DEPTH(10), .AFULL_TH(8), .AEMPTY_TH(2)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .write_enb(wr1), .data_in(din1),
    .read(rd1), .data_out(dout1), .empty(emp1), .full(ful1), .almost_empty(ae1),
    .almost_full(af1), .count(cnt1), .overflow(ovf1), .underflow(unf1)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic model_edge(int d, logic w, logic r, logic [7:0] di, logic c);
    int   size;
    int   depth;
    logic full_m;
    logic empty_m;
    depth   = (d == 0) ? 16 : 10;
    size    = (d == 0) ? exp_q0.size() : exp_q1.size();
    full_m  = (size == depth);
    empty_m = (size == 0);
    if (c) begin
      if (d == 0) begin
        exp_q0.delete(); exp_ovf0 = 1'b0; exp_unf0 = 1'b0; exp_reg0 = 8'h00;
      end else begin
        exp_q1.delete(); exp_ovf1 = 1'b0; exp_unf1 = 1'b0; exp_reg1 = 8'h00;
      end
    end else if (d == 0) begin
      if (w && full_m)   exp_ovf0 = 1'b1;
      if (r && empty_m)  exp_unf0 = 1'b1;
      if (r && !empty_m) exp_reg0 = exp_q0.pop_front();
      if (w && !full_m)  exp_q0.push_back(di);
    end else begin
      if (w && full_m)   exp_ovf1 = 1'b1;
      if (r && empty_m)  exp_unf1 = 1'b1;
      if (r && !empty_m) exp_reg1 = exp_q1.pop_front();
      if (w && !full_m)  exp_q1.push_back(di);
    end
  endtask

  task automatic model_reset();
    exp_q0.delete(); exp_q1.delete();
    exp_ovf0 = 1'b0; exp_unf0 = 1'b0; exp_ovf1 = 1'b0; exp_unf1 = 1'b0;
    exp_reg0 = 8'h00; exp_reg1 = 8'h00;
  endtask

  function automatic logic [7:0] exp_dout(int d);
`ifdef FIFO_FWFT_EN
    if (d == 0) return (exp_q0.size() == 0) ? 8'h00 : exp_q0[0];
    return (exp_q1.size() == 0) ? 8'h00 : exp_q1[0];
`else
    return (d == 0) ? exp_reg0 : exp_reg1;
`endif
  endfunction

  // {empty, full, almost_empty, almost_full, overflow, underflow}
  function automatic logic [5:0] exp_flags(int d);
    int size, depth, af, ae;
    logic o, u;
    if (d == 0) begin
      size = exp_q0.size(); depth = 16; af = 12; ae = 4; o = exp_ovf0; u = exp_unf0;
    end else begin
      size = exp_q1.size(); depth = 10; af = 8; ae = 2; o = exp_ovf1; u = exp_unf1;
    end
    return {size == 0, size == depth, size <= ae, size >= af, o, u};
  endfunction

  // ---------------- driver ----------------
  task automatic step(logic w0, logic r0, logic [7:0] d0,
                      logic w1, logic r1, logic [7:0] d1, logic c);
    wr0 = w0; rd0 = r0; din0 = d0; wr1 = w1; rd1 = r1; din1 = d1; clear = c;
    @(posedge clk);
    model_edge(0, w0, r0, d0, c);
    model_edge(1, w1, r1, d1, c);
    #1;
    wr0 = 1'b0; rd0 = 1'b0; wr1 = 1'b0; rd1 = 1'b0; clear = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cnt0 !== 5'd0) begin errors++; $display("FAIL reset_count0: got %0d expected 0", cnt0); end
    checks++; if ({emp0, ful0, ae0, af0, ovf0, unf0} !== 6'b101000) begin
      errors++; $display("FAIL reset_flags0: got %b expected 101000", {emp0, ful0, ae0, af0, ovf0, unf0}); end
    checks++; if (dout0 !== 8'h00) begin errors++; $display("FAIL reset_dout0: got %h expected 00", dout0); end
    checks++; if ({cnt1, emp1, ful1, ae1, af1, ovf1, unf1} !== {4'd0, 6'b101000}) begin
      errors++; $display("FAIL reset_dut1: got %b expected 0000101000", {cnt1, emp1, ful1, ae1, af1, ovf1, unf1}); end
    #2 reset = 1'b1;
  endtask

  task automatic test_fill_drain();
    logic exp_af;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0, 8'h00, 1'b0);
      exp_af = (i + 1 >= 12);
      checks++; if (cnt0 !== 5'(i + 1)) begin errors++; $display("FAIL fill_count: got %0d expected %0d", cnt0, i + 1); end
      checks++; if (af0 !== exp_af) begin errors++; $display("FAIL fill_afull: got %b expected %b at count %0d", af0, exp_af, i + 1); end
    end
    checks++; if ({ful0, emp0} !== 2'b10) begin errors++; $display("FAIL fill_full: got full=%b empty=%b expected 1 0", ful0, emp0); end
    for (int i = 0; i < 16; i++) begin
`ifdef FIFO_FWFT_EN
      checks++; if (dout0 !== 8'(i)) begin errors++; $display("FAIL drain_data: got %h expected %h", dout0, 8'(i)); end
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
`else
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      checks++; if (dout0 !== 8'(i)) begin errors++; $display("FAIL drain_data: got %h expected %h", dout0, 8'(i)); end
`endif
    end
    checks++; if ({emp0, cnt0} !== {1'b1, 5'd0}) begin errors++; $display("FAIL drain_empty: got empty=%b count=%0d expected 1 0", emp0, cnt0); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b0, 8'($urandom_range(0, 127)), 1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (ful0 !== 1'b1) begin errors++; $display("FAIL ovf_prefill_full: got %b expected 1", ful0); end
    step(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (cnt0 !== 5'd15) begin errors++; $display("FAIL ovf_count: got %0d expected 15", cnt0); end
    checks++; if (ovf0 !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", ovf0); end
    checks++; if (dout0 !== exp_dout(0)) begin errors++; $display("FAIL ovf_head: got %h expected %h", dout0, exp_dout(0)); end
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      checks++; if (dout0 !== exp_dout(0)) begin errors++; $display("FAIL ovf_drain_data: got %h expected %h", dout0, exp_dout(0)); end
    end
    checks++; if ({emp0, ovf0} !== 2'b11) begin errors++; $display("FAIL ovf_sticky: got empty=%b overflow=%b expected 1 1", emp0, ovf0); end
  endtask

  task automatic test_underflow();
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if ({unf0, cnt0} !== {1'b1, 5'd0}) begin errors++; $display("FAIL unf_flag: got underflow=%b count=%0d expected 1 0", unf0, cnt0); end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if ({unf0, ovf0} !== 2'b00) begin errors++; $display("FAIL unf_clear: got underflow=%b overflow=%b expected 0 0", unf0, ovf0); end
    step(1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if ({cnt0, unf0} !== {5'd1, 1'b1}) begin errors++; $display("FAIL empty_wr_rd: got count=%0d underflow=%b expected 1 1", cnt0, unf0); end
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (dout0 !== exp_dout(0)) begin errors++; $display("FAIL empty_wr_rd_data: got %h expected %h", dout0, exp_dout(0)); end
    step(1'b1, 1'b0, 8'h17, 1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if ({cnt0, emp0, dout0, unf0} !== {5'd0, 1'b1, 8'h00, 1'b0}) begin
      errors++; $display("FAIL clear_state: got count=%0d empty=%b dout=%h underflow=%b expected 0 1 00 0", cnt0, emp0, dout0, unf0); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 8'($urandom), 1'b1, 1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 8'($urandom), 1'b1, 1'b1, 8'($urandom), 1'b0);
      checks++; if ({cnt0, cnt1} !== {5'd5, 4'd5}) begin errors++; $display("FAIL wrap_count: got %0d/%0d expected 5/5", cnt0, cnt1); end
      checks++; if (dout0 !== exp_dout(0)) begin errors++; $display("FAIL wrap_data16: got %h expected %h", dout0, exp_dout(0)); end
      checks++; if (dout1 !== exp_dout(1)) begin errors++; $display("FAIL wrap_data10: got %h expected %h", dout1, exp_dout(1)); end
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
      checks++; if ({dout0, dout1} !== {exp_dout(0), exp_dout(1)}) begin
        errors++; $display("FAIL wrap_drain: got %h/%h expected %h/%h", dout0, dout1, exp_dout(0), exp_dout(1)); end
    end
  endtask

  task automatic test_random();
    logic w0, r0, w1, r1, c;
    int   pw;
    for (int n = 0; n < 400; n++) begin
      pw = (n < 200) ? 70 : 30;
      w0 = ($urandom_range(0, 99) < pw);
      r0 = ($urandom_range(0, 99) < 100 - pw);
      w1 = ($urandom_range(0, 99) < pw);
      r1 = ($urandom_range(0, 99) < 100 - pw);
      c  = ($urandom_range(0, 149) == 0);
      step(w0, r0, 8'($urandom), w1, r1, 8'($urandom), c);
      checks++; if (cnt0 !== 5'(exp_q0.size())) begin errors++; $display("FAIL rand_count16: got %0d expected %0d", cnt0, exp_q0.size()); end
      checks++; if ({emp0, ful0, ae0, af0, ovf0, unf0} !== exp_flags(0)) begin
        errors++; $display("FAIL rand_flags16: got %b expected %b", {emp0, ful0, ae0, af0, ovf0, unf0}, exp_flags(0)); end
      checks++; if (dout0 !== exp_dout(0)) begin errors++; $display("FAIL rand_data16: got %h expected %h", dout0, exp_dout(0)); end
      checks++; if (cnt1 !== 4'(exp_q1.size())) begin errors++; $display("FAIL rand_count10: got %0d expected %0d", cnt1, exp_q1.size()); end
      checks++; if ({emp1, ful1, ae1, af1, ovf1, unf1} !== exp_flags(1)) begin
        errors++; $display("FAIL rand_flags10: got %b expected %b", {emp1, ful1, ae1, af1, ovf1, unf1}, exp_flags(1)); end
      checks++; if (dout1 !== exp_dout(1)) begin errors++; $display("FAIL rand_data10: got %h expected %h", dout1, exp_dout(1)); end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++)
      step(1'b1, 1'b0, 8'($urandom), 1'b1, 1'b0, 8'($urandom), 1'b0);
    step(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b1, 8'h00, 1'b0);
    checks++; if (cnt0 !== 5'd7) begin errors++; $display("FAIL mid_precount: got %0d expected 7", cnt0); end
    wr0 = 1'b1; rd0 = 1'b1; din0 = 8'hEE; wr1 = 1'b1; din1 = 8'hEE;
    #2 reset = 1'b0;
    #1;
    checks++; if ({cnt0, emp0, ful0, ae0, af0, ovf0, unf0, dout0} !== {5'd0, 6'b101000, 8'h00}) begin
      errors++; $display("FAIL mid_async: got count=%0d flags=%b dout=%h expected 0 101000 00", cnt0, {emp0, ful0, ae0, af0, ovf0, unf0}, dout0); end
    checks++; if ({cnt1, emp1, dout1} !== {4'd0, 1'b1, 8'h00}) begin
      errors++; $display("FAIL mid_async10: got count=%0d empty=%b dout=%h expected 0 1 00", cnt1, emp1, dout1); end
    @(posedge clk);
    #1;
    checks++; if ({cnt0, emp0, cnt1} !== {5'd0, 1'b1, 4'd0}) begin
      errors++; $display("FAIL mid_held: got count=%0d empty=%b count10=%0d expected 0 1 0", cnt0, emp0, cnt1); end
    wr0 = 1'b0; rd0 = 1'b0; wr1 = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    step(1'b1, 1'b0, 8'h5C, 1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (cnt0 !== 5'd1) begin errors++; $display("FAIL post_reset_count: got %0d expected 1", cnt0); end
`ifdef FIFO_FWFT_EN
    checks++; if (dout0 !== 8'h5C) begin errors++; $display("FAIL post_reset_data: got %h expected 5c", dout0); end
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
`else
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (dout0 !== 8'h5C) begin errors++; $display("FAIL post_reset_data: got %h expected 5c", dout0); end
`endif
  endtask

  task automatic test_data_out_mode();
`ifdef FIFO_FWFT_EN
    step(1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if ({emp0, dout0} !== {1'b0, 8'h33}) begin errors++; $display("FAIL fwft_show: got empty=%b dout=%h expected 0 33", emp0, dout0); end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (dout0 !== 8'h33) begin errors++; $display("FAIL fwft_hold: got %h expected 33", dout0); end
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if ({emp0, dout0} !== {1'b1, 8'h00}) begin errors++; $display("FAIL fwft_ack: got empty=%b dout=%h expected 1 00", emp0, dout0); end
`else
    step(1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (dout0 !== 8'h11) begin errors++; $display("FAIL reg_load: got %h expected 11", dout0); end
    step(1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if ({dout0, cnt0} !== {8'h11, 5'd1}) begin errors++; $display("FAIL reg_hold: got dout=%h count=%0d expected 11 1", dout0, cnt0); end
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if ({dout0, emp0} !== {8'h22, 1'b1}) begin errors++; $display("FAIL reg_next: got dout=%h empty=%b expected 22 1", dout0, emp0); end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_wrap();
    test_random();
    test_reset_mid();
    test_data_out_mode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
